// File: rtl/pc_unit.sv
// Program-counter unit: next-PC selection, stall hold, EPC capture on exception.
// Define PC_RAS_EN to build in the hardware return-address stack.
module pc_unit #(
   parameter int             N         = 32,
   parameter int             STEP      = 1,
   parameter logic [N-1:0]   RESET_VEC = '0,
   parameter logic [N-1:0]   EXC_VEC   = 'h40,
   parameter int             RAS_DEPTH = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         stall,
   input  logic         exc,
   input  logic         jump,
   input  logic         call,
   input  logic         ret,
   input  logic         pc_src,
   input  logic [N-1:0] jump_address,
   input  logic [N-1:0] branch_offset,
   input  logic [N-1:0] ret_address,
   output logic [N-1:0] pc_out,
   output logic [N-1:0] pc_plus,
   output logic [N-1:0] epc,
   output logic         ras_empty,
   output logic         ras_full
);

   logic [N-1:0] pc_next;
   logic         ras_hit;
   logic [N-1:0] ras_top;
   logic         advance;

   assign pc_plus = pc_out + N'(STEP);
   assign advance = !exc && !stall;

   // Priority chain: exception beats stall, which beats every redirect.
   always_comb begin
      pc_next = pc_plus;
      if (exc)
         pc_next = EXC_VEC;
      else if (stall)
         pc_next = pc_out;
      else if (call || jump)
         pc_next = jump_address;
      else if (ret)
         pc_next = ras_hit ? ras_top : ret_address;
      else if (pc_src)
         pc_next = pc_out + branch_offset;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_out <= RESET_VEC;
         epc    <= '0;
      end else begin
         pc_out <= pc_next;
         if (exc)
            epc <= pc_out;
      end
   end

`ifdef PC_RAS_EN
   localparam int PW = $clog2(RAS_DEPTH);

   logic [N-1:0]  ras_mem [RAS_DEPTH];
   logic [PW-1:0] ras_ptr;
   logic [PW:0]   ras_count;
   logic          do_push;
   logic          do_pop;

   // ras_ptr names the next free slot; wrapping it makes a full push overwrite the oldest entry.
   assign ras_hit   = (ras_count != '0);
   assign ras_top   = ras_mem[ras_ptr - 1'b1];
   assign do_push   = advance && call;
   assign do_pop    = advance && !call && !jump && ret && ras_hit;
   assign ras_empty = (ras_count == '0);
   assign ras_full  = (ras_count == (PW+1)'(RAS_DEPTH));

   always_ff @(posedge clk) begin
      if (reset) begin
         ras_ptr   <= '0;
         ras_count <= '0;
      end else if (do_push) begin
         ras_ptr <= ras_ptr + 1'b1;
         if (!ras_full)
            ras_count <= ras_count + 1'b1;
      end else if (do_pop) begin
         ras_ptr   <= ras_ptr - 1'b1;
         ras_count <= ras_count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && do_push)
         ras_mem[ras_ptr] <= pc_plus;
   end
`else
   assign ras_hit   = 1'b0;
   assign ras_top   = '0;
   assign ras_empty = 1'b1;
   assign ras_full  = 1'b0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: a queue-based reference model compared every cycle,
// plus directed vectors with literal expectations.
module tb_pc_unit;

   localparam int N         = 32;
   localparam int STEP      = 1;
   localparam int RAS_DEPTH = 4;

   logic         clk = 1'b0;
   logic         reset;
   logic         stall, exc, jump, call, ret, pc_src;
   logic [N-1:0] jump_address, branch_offset, ret_address;
   logic [N-1:0] pc_out, pc_plus, epc;
   logic         ras_empty, ras_full;

   int total = 0;
   int bad   = 0;

   pc_unit #(
      .N(N), .STEP(STEP), .RESET_VEC(32'd0), .EXC_VEC(32'h40), .RAS_DEPTH(RAS_DEPTH)
   ) dut (
      .clk(clk), .reset(reset), .stall(stall), .exc(exc), .jump(jump), .call(call),
      .ret(ret), .pc_src(pc_src), .jump_address(jump_address),
      .branch_offset(branch_offset), .ret_address(ret_address),
      .pc_out(pc_out), .pc_plus(pc_plus), .epc(epc),
      .ras_empty(ras_empty), .ras_full(ras_full)
   );

   always #5 clk = ~clk;

   // Reference model: PC and EPC as plain integers, the return stack as a bounded queue.
   logic [N-1:0] m_pc, m_epc;
   logic [N-1:0] m_ras [$];
   bit           m_valid = 0;

   always @(posedge clk) begin
      if (reset) begin
         m_pc    = 32'd0;
         m_epc   = 32'd0;
         m_ras.delete();
         m_valid = 1;
      end else if (m_valid) begin
         if (exc) begin
            m_epc = m_pc;
            m_pc  = 32'h40;
         end else if (stall) begin
            m_pc = m_pc;
         end else if (call || jump) begin
`ifdef PC_RAS_EN
            if (call) begin
               if (m_ras.size() == RAS_DEPTH) m_ras.delete(0);
               m_ras.push_back(m_pc + STEP);
            end
`endif
            m_pc = jump_address;
         end else if (ret) begin
            if (m_ras.size() > 0) m_pc = m_ras.pop_back();
            else m_pc = ret_address;
         end else if (pc_src) begin
            m_pc = m_pc + branch_offset;
         end else begin
            m_pc = m_pc + STEP;
         end
      end
   end

   // Cycle-by-cycle comparison, sampled on the falling edge.
   always @(negedge clk) begin
      if (m_valid) begin
         total += 5;
         if (pc_out !== m_pc) begin
            bad++;
            $display("[TB] FAIL model_pc: got %h expected %h", pc_out, m_pc);
         end
         if (pc_plus !== m_pc + STEP) begin
            bad++;
            $display("[TB] FAIL model_pc_plus: got %h expected %h", pc_plus, m_pc + STEP);
         end
         if (epc !== m_epc) begin
            bad++;
            $display("[TB] FAIL model_epc: got %h expected %h", epc, m_epc);
         end
         if (ras_empty !== (m_ras.size() == 0)) begin
            bad++;
            $display("[TB] FAIL model_ras_empty: got %b expected %b", ras_empty, m_ras.size() == 0);
         end
         if (ras_full !== (m_ras.size() == RAS_DEPTH)) begin
            bad++;
            $display("[TB] FAIL model_ras_full: got %b expected %b", ras_full, m_ras.size() == RAS_DEPTH);
         end
      end
   end

   task automatic checkOutput(input string name, input logic [N-1:0] actual, input logic [N-1:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   // Drive one cycle of requests, then return after the edge has been taken.
   task automatic applyStimulus(input logic s, input logic e, input logic j, input logic c,
                                input logic r, input logic b, input logic [N-1:0] ja,
                                input logic [N-1:0] bo, input logic [N-1:0] ra);
      stall = s; exc = e; jump = j; call = c; ret = r; pc_src = b;
      jump_address = ja; branch_offset = bo; ret_address = ra;
      @(negedge clk);
   endtask

   task automatic idle();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic jumpTo(input logic [N-1:0] a);
      applyStimulus(0, 0, 1, 0, 0, 0, a, 0, 0);
   endtask

   initial begin
      reset = 1;
      stall = 0; exc = 0; jump = 0; call = 0; ret = 0; pc_src = 0;
      jump_address = 0; branch_offset = 0; ret_address = 0;
      @(negedge clk);
      @(negedge clk);
      checkOutput("reset_pc", pc_out, 32'd0);
      checkOutput("reset_epc", epc, 32'd0);
      checkOutput("reset_empty", {31'd0, ras_empty}, 32'd1);
      checkOutput("reset_full", {31'd0, ras_full}, 32'd0);
      reset = 0;

      // Sequential run and wrap
      idle(); checkOutput("seq1", pc_out, 32'd1);
      idle(); checkOutput("seq2", pc_out, 32'd2);
      idle(); checkOutput("seq3", pc_out, 32'd3);
      checkOutput("pc_plus3", pc_plus, 32'd4);
      jumpTo(32'hFFFF_FFFF); checkOutput("at_max", pc_out, 32'hFFFF_FFFF);
      idle(); checkOutput("wrap", pc_out, 32'd0);

      // Branch and jump-over-branch priority
      jumpTo(32'd10);
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 32'hFFFF_FFFD, 0);
      checkOutput("branch_neg", pc_out, 32'd7);
      applyStimulus(0, 0, 1, 0, 0, 1, 32'd100, 32'd5, 0);
      checkOutput("jump_wins", pc_out, 32'd100);

      // Stall hold, then exception through stall
      jumpTo(32'd20);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1, 0, 1, 0, 0, 0, 32'd55, 0, 0);
         checkOutput("stall_hold", pc_out, 32'd20);
      end
      applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("exc_pc", pc_out, 32'h40);
      checkOutput("exc_epc", epc, 32'd20);

`ifdef PC_RAS_EN
      // Nested calls and returns
      jumpTo(32'd5);
      applyStimulus(0, 0, 0, 1, 0, 0, 32'd50, 0, 0); checkOutput("call1", pc_out, 32'd50);
      applyStimulus(0, 0, 0, 1, 0, 0, 32'd80, 0, 0); checkOutput("call2", pc_out, 32'd80);
      applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 32'd999); checkOutput("ret1", pc_out, 32'd51);
      applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 32'd999); checkOutput("ret2", pc_out, 32'd6);
      checkOutput("ret_empty", {31'd0, ras_empty}, 32'd1);
      applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 32'd9); checkOutput("ret_fallback", pc_out, 32'd9);

      // Overflow drops the oldest entry
      jumpTo(32'd1);
      for (int i = 2; i <= 6; i++)
         applyStimulus(0, 0, 0, 1, 0, 0, i, 0, 0);
      checkOutput("full_flag", {31'd0, ras_full}, 32'd1);
      for (int i = 6; i >= 3; i--) begin
         applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 32'd999);
         checkOutput("overflow_ret", pc_out, i);
      end
      applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 32'd123);
      checkOutput("overflow_fallback", pc_out, 32'd123);

      // call and ret together: call wins, nothing popped
      jumpTo(32'd40);
      applyStimulus(0, 0, 0, 1, 1, 0, 32'd30, 0, 32'd7);
      checkOutput("call_ret_pc", pc_out, 32'd30);
      applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 32'd7);
      checkOutput("call_ret_after", pc_out, 32'd41);
`else
      // Without the stack, call is a plain jump and ret uses the register value
      jumpTo(32'd5);
      applyStimulus(0, 0, 0, 1, 0, 0, 32'd50, 0, 0); checkOutput("call_nras", pc_out, 32'd50);
      checkOutput("empty_nras", {31'd0, ras_empty}, 32'd1);
      applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 32'd77); checkOutput("ret_nras", pc_out, 32'd77);
      checkOutput("full_nras", {31'd0, ras_full}, 32'd0);
`endif

      // Reset mid-sequence clears epc and the stack together
      jumpTo(32'd12);
      applyStimulus(0, 0, 0, 1, 0, 0, 32'd90, 0, 0);
      applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("pre_reset_epc", epc, 32'd90);
      reset = 1;
      idle();
      reset = 0;
      checkOutput("midreset_pc", pc_out, 32'd0);
      checkOutput("midreset_epc", epc, 32'd0);
      checkOutput("midreset_empty", {31'd0, ras_empty}, 32'd1);
      applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 32'd66);
      checkOutput("midreset_ret", pc_out, 32'd66);

      idle();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
